// File: rtl/adder_pipe_seg.sv
// Carry-pipelined ripple adder/subtractor: one SEG_W-bit segment per stage, valid/ready handshake.
// The whole pipe advances together when the output slot is empty or being drained.
module adder_pipe_seg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned SEG_SAFE = (SEG_W >= 1) ? SEG_W : 1;
  localparam int unsigned NSEG     = WIDTH / SEG_SAFE;
  localparam int unsigned SW1      = SEG_SAFE + 1;

  if ((SEG_W < 1) || (WIDTH % SEG_SAFE != 0)) begin : g_bad_param
    $error("adder_pipe_seg: WIDTH must be a nonzero multiple of SEG_W");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             vld_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign en        = !vld_q || out_ready;
  assign in_ready  = en;
  assign b_eff     = sub ? ~b : b;
  assign c0        = sub | cin;
  assign out_valid = vld_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Intermediate stages: stage k holds sum bits of segments 0..k plus the unconsumed operand tails.
  for (genvar k = 0; k < int'(NSEG) - 1; k++) begin : g_stg
    localparam int unsigned LO_W  = (unsigned'(k) + 1) * SEG_SAFE;
    localparam int unsigned REM_W = WIDTH - LO_W;

    logic [SEG_SAFE-1:0] sa;
    logic [SEG_SAFE-1:0] sb;
    logic                si;
    logic                vi;
    logic [SW1-1:0]      t;
    logic [LO_W-1:0]     lo_d;
    logic [LO_W-1:0]     lo_q;
    logic [REM_W-1:0]    a_d;
    logic [REM_W-1:0]    b_d;
    logic [REM_W-1:0]    a_q;
    logic [REM_W-1:0]    b_q;
    logic                c_q;
    logic                v_q;

    if (k == 0) begin : g_src
      assign sa   = a[SEG_SAFE-1:0];
      assign sb   = b_eff[SEG_SAFE-1:0];
      assign si   = c0;
      assign vi   = in_valid;
      assign lo_d = t[SEG_SAFE-1:0];
      assign a_d  = a[WIDTH-1:SEG_SAFE];
      assign b_d  = b_eff[WIDTH-1:SEG_SAFE];
    end else begin : g_src
      assign sa   = g_stg[k-1].a_q[SEG_SAFE-1:0];
      assign sb   = g_stg[k-1].b_q[SEG_SAFE-1:0];
      assign si   = g_stg[k-1].c_q;
      assign vi   = g_stg[k-1].v_q;
      assign lo_d = {t[SEG_SAFE-1:0], g_stg[k-1].lo_q};
      assign a_d  = g_stg[k-1].a_q[REM_W+SEG_SAFE-1:SEG_SAFE];
      assign b_d  = g_stg[k-1].b_q[REM_W+SEG_SAFE-1:SEG_SAFE];
    end

    assign t = SW1'(sa) + SW1'(sb) + SW1'(si);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        lo_q <= '0;
        a_q  <= '0;
        b_q  <= '0;
      end else if (en) begin
        v_q  <= vi;
        c_q  <= t[SEG_SAFE];
        lo_q <= lo_d;
        a_q  <= a_d;
        b_q  <= b_d;
      end
    end
  end

  logic [SEG_SAFE-1:0] fa;
  logic [SEG_SAFE-1:0] fb;
  logic                fc;
  logic                fv;
  logic [SW1-1:0]      ft;
  logic [WIDTH-1:0]    sum_d;
  logic                ovf_d;

  // Final segment feeds the output register; with one segment it reads the ports directly.
  if (NSEG == 1) begin : g_fin
    assign fa    = a;
    assign fb    = b_eff;
    assign fc    = c0;
    assign fv    = in_valid;
    assign sum_d = ft[SEG_SAFE-1:0];
  end else begin : g_fin
    assign fa    = g_stg[NSEG-2].a_q;
    assign fb    = g_stg[NSEG-2].b_q;
    assign fc    = g_stg[NSEG-2].c_q;
    assign fv    = g_stg[NSEG-2].v_q;
    assign sum_d = {ft[SEG_SAFE-1:0], g_stg[NSEG-2].lo_q};
  end

  assign ft = SW1'(fa) + SW1'(fb) + SW1'(fc);
  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign ovf_d = ft[SEG_SAFE-1] ^ fa[SEG_SAFE-1] ^ fb[SEG_SAFE-1] ^ ft[SEG_SAFE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      vld_q  <= fv;
      sum_q  <= sum_d;
      cout_q <= ft[SEG_SAFE];
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_pipe_seg.sv
// Bench for adder_pipe_seg: three instances (SEG_W = 1, 8, 32) share stimulus and are
// checked every cycle against a per-instance delay-line model of arithmetic results.
module tb_adder_pipe_seg;
  localparam int W = 32;

  typedef struct {
    bit          v;
    logic [31:0] s;
    bit          c;
    bit          o;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_ready;

  logic [2:0]  in_ready_w;
  logic [2:0]  out_valid_w;
  logic [2:0]  cout_w;
  logic [2:0]  ovf_w;
  logic [31:0] sum_w [3];

  int checks   = 0;
  int failures = 0;

  int    nseg [3] = '{32, 4, 1};
  beat_t pipe [3][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned SW = (g == 0) ? 1 : (g == 1) ? 8 : 32;
    adder_pipe_seg #(.WIDTH(W), .SEG_W(SW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .sum       (sum_w[g]),
      .cout      (cout_w[g]),
      .ovf       (ovf_w[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: plain 33-bit add of the effective operands.
  function automatic beat_t ref_beat(input logic [31:0] x, input logic [31:0] y,
                                     input logic ci, input logic sb);
    beat_t       r;
    logic [31:0] ye;
    logic [32:0] t;
    ye  = sb ? ~y : y;
    t   = {1'b0, x} + {1'b0, ye} + 33'(sb ? 1'b1 : ci);
    r.v = 1'b1;
    r.s = t[31:0];
    r.c = t[32];
    r.o = (x[31] == ye[31]) && (t[31] != x[31]);
    return r;
  endfunction

  function automatic beat_t empty_beat();
    beat_t r;
    r.v = 1'b0;
    r.s = '0;
    r.c = 1'b0;
    r.o = 1'b0;
    return r;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      pipe[d].delete();
      for (int i = 0; i < nseg[d]; i++) pipe[d].push_back(empty_beat());
    end
  endtask

  // Model step on each edge, then compare every instance shortly after it.
  always @(posedge clk) begin
    beat_t nb;
    beat_t ex;
    bit    en;
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int d = 0; d < 3; d++) begin
        en = !pipe[d][$].v || out_ready;
        if (en) begin
          nb = in_valid ? ref_beat(a, b, cin, sub) : empty_beat();
          void'(pipe[d].pop_back());
          pipe[d].push_front(nb);
        end
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      ex = pipe[d][$];
      chk($sformatf("out_valid[%0d]", d), 32'(out_valid_w[d]), 32'(ex.v));
      chk($sformatf("in_ready[%0d]", d), 32'(in_ready_w[d]), 32'(!ex.v || out_ready));
      if (ex.v) begin
        chk($sformatf("sum[%0d]", d), sum_w[d], ex.s);
        chk($sformatf("cout[%0d]", d), 32'(cout_w[d]), 32'(ex.c));
        chk($sformatf("ovf[%0d]", d), 32'(ovf_w[d]), 32'(ex.o));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic sb);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = ci;
    sub      = sb;
    @(negedge clk);
  endtask

  task automatic drive_rand(input int pct_valid);
    drive(32'($urandom_range(0, 99)) < 32'(pct_valid), $urandom(), $urandom(),
          1'($urandom()), 1'($urandom()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom(), $urandom(), 1'b0, 1'b0);
  endtask

  task automatic reset_check(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s out_valid[%0d]", tag, d), 32'(out_valid_w[d]), 32'd0);
      chk($sformatf("%s sum[%0d]", tag, d), sum_w[d], 32'd0);
      chk($sformatf("%s cout_ovf[%0d]", tag, d), 32'({cout_w[d], ovf_w[d]}), 32'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    #1;
    reset_check("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("post-reset in_ready[%0d]", d), 32'(in_ready_w[d]), 32'd1);

    // Carry ripple through all segments.
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("nseg1 valid edge1", 32'(out_valid_w[2]), 32'd1);
    chk("nseg1 sum edge1", sum_w[2], 32'h0000_0000);
    chk("nseg4 not yet edge1", 32'(out_valid_w[1]), 32'd0);
    idle(2);
    chk("nseg4 not yet edge3", 32'(out_valid_w[1]), 32'd0);
    idle(1);
    chk("carry valid", 32'(out_valid_w[1]), 32'd1);
    chk("carry sum", sum_w[1], 32'h0000_0000);
    chk("carry cout", 32'(cout_w[1]), 32'd1);
    chk("carry ovf", 32'(ovf_w[1]), 32'd0);
    idle(35);

    // Subtract with borrow, then signed overflow, back to back.
    drive(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    idle(2);
    chk("sub sum", sum_w[1], 32'hFFFF_FFFE);
    chk("sub cout", 32'(cout_w[1]), 32'd0);
    chk("sub ovf", 32'(ovf_w[1]), 32'd0);
    idle(1);
    chk("ovf sum", sum_w[1], 32'h8000_0000);
    chk("ovf cout", 32'(cout_w[1]), 32'd0);
    chk("ovf ovf", 32'(ovf_w[1]), 32'd1);
    idle(35);

    // Eight back-to-back random beats at full throughput.
    for (int i = 0; i < 8; i++) drive_rand(100);
    idle(40);

    // Four beats then five stalled cycles with the head held at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_rand(100);
    idle(5);
    chk("stall in_ready nseg4", 32'(in_ready_w[1]), 32'd0);
    out_ready = 1'b1;
    idle(40);

    // Reset mid-stream with three beats in flight.
    for (int i = 0; i < 3; i++) drive_rand(100);
    rst_n = 1'b0;
    #1;
    reset_check("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    drive(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    idle(40);

    // Random traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      out_ready = 1'($urandom_range(0, 99) < 60);
      drive_rand(70);
    end
    out_ready = 1'b1;
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
